// File: rtl/mine_scan_sequencer.sv
// Self-test sequencer for Neural_net_controller: walks the four switches through
// all 16 patterns, lets each settle, then captures both indicators per pattern.
module mine_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        indikator_1,
  input  logic        indikator_2,
  output logic        switch_1,
  output logic        switch_2,
  output logic        switch_3,
  output logic        switch_4,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  mine_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         pattern_q, pattern_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [3:0]         switches_q, switches_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         mine_count_q, mine_count_d;

  // Next-state and next-output logic; outputs derive from the next state so they are registered.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    counter_d    = counter_q;
    result_d     = result_q;
    mine_count_d = mine_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          pattern_d    = 4'd0;
          counter_d    = '0;
          result_d     = 32'd0;
          mine_count_d = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (counter_q == LAST_CNT) begin
          state_d   = SAMPLE;
          counter_d = '0;
        end else begin
          counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      SAMPLE: begin
        // Indicators are only looked at here, so settling glitches never reach the result.
        result_d[{pattern_q, 1'b0} +: 2] = {indikator_2, indikator_1};
        mine_count_d = mine_count_q + {4'd0, indikator_1};
        if (pattern_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d   = SETTLE;
          pattern_d = pattern_q + 4'd1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        pattern_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        pattern_d = 4'd0;
        counter_d = '0;
      end
    endcase

    if (state_d == IDLE) begin
      switches_d = 4'd0;
    end else begin
      switches_d = pattern_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pattern_q    <= 4'd0;
      counter_q    <= '0;
      switches_q   <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 32'd0;
      mine_count_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      counter_q    <= counter_d;
      switches_q   <= switches_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      mine_count_q <= mine_count_d;
    end
  end

  assign switch_1   = switches_q[3];
  assign switch_2   = switches_q[2];
  assign switch_3   = switches_q[1];
  assign switch_4   = switches_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign mine_count = mine_count_q;

endmodule

// File: tb/tb_mine_scan_sequencer.sv
// Directed bench for mine_scan_sequencer: table of full scans against a stub
// controller, plus hand sequences for reset, mid-scan reset and held start.
module tb_mine_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        indikator_1;
  logic        indikator_2;
  logic        switch_1, switch_2, switch_3, switch_4;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  mine_count;
  logic [2:0]  mode;
  logic [3:0]  sw;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] exp_result;
    logic [4:0]  exp_count;
    bit          extra_start;
  } vec_t;

  vec_t vecs [6];

  mine_scan_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .indikator_1 (indikator_1),
    .indikator_2 (indikator_2),
    .switch_1    (switch_1),
    .switch_2    (switch_2),
    .switch_3    (switch_3),
    .switch_4    (switch_4),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mine_count  (mine_count)
  );

  always #5 clk = ~clk;

  assign sw = {switch_1, switch_2, switch_3, switch_4};

  // Stub controller: indicator response as a function of the applied pattern.
  always_comb begin
    indikator_1 = 1'b0;
    indikator_2 = 1'b0;
    case (mode)
      3'd0: begin
        indikator_1 = (sw == 4'b0011) || (sw == 4'b0110);
        indikator_2 = ~indikator_1;
      end
      3'd1: begin
        indikator_1 = 1'b1;
        indikator_2 = 1'b1;
      end
      3'd3: indikator_1 = sw[0];
      3'd4: indikator_2 = sw[3];
      default: begin
        indikator_1 = 1'b0;
        indikator_2 = 1'b0;
      end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, sw, busy, done, result, mine_count}, 64'd0);
  endtask

  // One full scan: every cycle checks pattern, busy and done; result checked at the end.
  task automatic run_scan(input logic [2:0] m, input logic [31:0] exp_res,
                          input logic [4:0] exp_cnt, input bit extra);
    logic [3:0] exp_sw;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 48; e++) begin
      @(negedge clk);
      start = extra && (e == 9 || e == 48);
      exp_sw = (e == 48) ? 4'hF : 4'(e / 3);
      check("seq", {58'd0, exp_sw == sw, busy, done, 3'd0},
                   {58'd0, 1'b1, 1'b1, (e == 48), 3'd0});
      if (e == 0) check("clear_at_accept", {27'd0, result, mine_count}, 64'd0);
      if (e < 48) @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("result", {32'd0, result}, {32'd0, exp_res});
    check("mine_count", {59'd0, mine_count}, {59'd0, exp_cnt});
    for (int i = 0; i < 3; i++) begin
      check("idle_after", {58'd0, sw, busy, done}, 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hAAAA9A6A, 5'd2,  1'b0};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 5'd16, 1'b0};
    vecs[2] = '{3'd2, 32'h00000000, 5'd0,  1'b1};
    vecs[3] = '{3'd3, 32'h44444444, 5'd8,  1'b0};
    vecs[4] = '{3'd4, 32'hAAAA0000, 5'd0,  1'b1};
    vecs[5] = '{3'd0, 32'hAAAA9A6A, 5'd2,  1'b0};

    rst = 1'b1;
    start = 1'b0;
    mode = 3'd2;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_all_zero("reset_idle");
      @(negedge clk);
    end

    for (int v = 0; v < 6; v++)
      run_scan(vecs[v].mode, vecs[v].exp_result, vecs[v].exp_count, vecs[v].extra_start);

    // Asynchronous reset in the middle of a clock period, partway through a scan.
    mode = 3'd1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (20) @(posedge clk);
    check("busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk) rst = 1'b0;
    check_all_zero("after_rst");
    run_scan(3'd0, 32'hAAAA9A6A, 5'd2, 1'b0);

    // start held high: the next scan is accepted on the edge after DONE->IDLE.
    mode = 3'd1;
    @(negedge clk) start = 1'b1;
    begin : wait_done
      int n;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("held_done_seen", {63'd0, done}, 64'd1);
    end
    @(negedge clk);
    check("held_idle_gap", {58'd0, sw, busy, done}, 64'd0);
    @(negedge clk);
    check("held_restart", {58'd0, sw, busy, done}, {58'd0, 4'd0, 1'b1, 1'b0});
    check("held_clear", {27'd0, result, mine_count}, 64'd0);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
